// File: rtl/vid_aes_pkg.sv
// Shared types, sizes and address-wrap helper for the video-memory AES sequencer.
package vid_aes_pkg;

    localparam int unsigned DATA_W = 1024;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DEPTH  = 3601;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        SEND,
        RECV,
        WR,
        DONE
    } state_t;

    // Word address after addr, wrapping at the end of the memory.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr);
        return (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + ADDR_W'(1);
    endfunction

endpackage

// File: rtl/vid_mem_aes_sequencer_if.sv
// Memory-port and AES-engine signals between the sequencer (master) and memory/engine (slave).
interface vid_mem_aes_sequencer_if;
    import vid_aes_pkg::*;

    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect;
    logic              mem_write;
    logic [BE_W-1:0]   mem_byteenable;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    logic              eng_in_valid;
    logic              eng_in_ready;
    logic [DATA_W-1:0] eng_in_data;
    logic              eng_out_valid;
    logic              eng_out_ready;
    logic [DATA_W-1:0] eng_out_data;

    modport master (
        output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata, mem_clken,
        input  mem_readdata,
        output eng_in_valid, eng_in_data, eng_out_ready,
        input  eng_in_ready, eng_out_valid, eng_out_data
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata, mem_clken,
        output mem_readdata,
        input  eng_in_valid, eng_in_data, eng_out_ready,
        output eng_in_ready, eng_out_valid, eng_out_data
    );

endinterface

// File: rtl/vid_mem_aes_sequencer.sv
// Walks a wrap-around range of memory words: read, pass through the AES engine, write back in place.
module vid_mem_aes_sequencer
    import vid_aes_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W-1:0]       num_words,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [ADDR_W-1:0]       words_done,
    vid_mem_aes_sequencer_if.master bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] remaining_q;
    logic [DATA_W-1:0] buf_q;
    logic              abort_pending_q;
    logic              abort_now_c;

    logic              cs_q, write_q, in_valid_q, out_ready_q;
    logic [BE_W-1:0]   be_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // An abort arriving in the WR cycle itself still ends the job at this boundary.
    always_comb begin
        state_d     = state_q;
        abort_now_c = abort_pending_q | abort;
        case (state_q)
            IDLE: begin
                if (start) state_d = (num_words == '0) ? DONE : RD;
            end
            RD:   state_d = CAP;
            CAP:  state_d = SEND;
            SEND: begin
                if (bus.eng_in_ready) state_d = RECV;
            end
            RECV: begin
                if (bus.eng_out_valid) state_d = WR;
            end
            WR:   state_d = (remaining_q == ADDR_W'(1) || abort_now_c) ? DONE : RD;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Job registers: address walk, word counters, abort bookkeeping and the single data buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q          <= '0;
            remaining_q     <= '0;
            words_done      <= '0;
            aborted         <= 1'b0;
            abort_pending_q <= 1'b0;
            buf_q           <= '0;
        end else begin
            if (state_q != IDLE && abort) abort_pending_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q          <= (32'(base_addr) >= DEPTH) ? '0 : base_addr;
                        remaining_q     <= num_words;
                        words_done      <= '0;
                        aborted         <= 1'b0;
                        abort_pending_q <= 1'b0;
                    end
                end
                CAP: buf_q <= bus.mem_readdata;
                RECV: begin
                    if (bus.eng_out_valid) buf_q <= bus.eng_out_data;
                end
                WR: begin
                    words_done  <= words_done + ADDR_W'(1);
                    remaining_q <= remaining_q - ADDR_W'(1);
                    addr_q      <= next_addr(addr_q);
                    if (abort_now_c) begin
                        aborted         <= 1'b1;
                        abort_pending_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            cs_q        <= 1'b0;
            write_q     <= 1'b0;
            be_q        <= '0;
            in_valid_q  <= 1'b0;
            out_ready_q <= 1'b0;
        end else begin
            busy        <= (state_d != IDLE);
            done        <= (state_d == DONE);
            cs_q        <= (state_d == RD) || (state_d == WR);
            write_q     <= (state_d == WR);
            be_q        <= (state_d == WR) ? '1 : '0;
            in_valid_q  <= (state_d == SEND);
            out_ready_q <= (state_d == RECV);
        end
    end

    assign bus.mem_address    = addr_q;
    assign bus.mem_chipselect = cs_q;
    assign bus.mem_write      = write_q;
    assign bus.mem_byteenable = be_q;
    assign bus.mem_writedata  = buf_q;
    assign bus.mem_clken      = 1'b1;
    assign bus.eng_in_valid   = in_valid_q;
    assign bus.eng_in_data    = buf_q;
    assign bus.eng_out_ready  = out_ready_q;

endmodule

// File: tb/tb_vid_mem_aes_sequencer.sv
// Bench for vid_mem_aes_sequencer: memory and XOR-engine models with an address-walk reference image.
module tb_vid_mem_aes_sequencer;
    import vid_aes_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] num_words = '0;
    logic              busy, done, aborted;
    logic [ADDR_W-1:0] words_done;

    vid_mem_aes_sequencer_if bus();

    vid_mem_aes_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .num_words  (num_words),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .words_done (words_done),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [DATA_W-1:0] exp_mem [DEPTH];
    logic [ADDR_W-1:0] rd_addr;
    logic              init_req = 1'b0;
    logic [DATA_W-1:0] mask = '1;
    int                in_stall = 0;
    int                out_stall = 0;

    function automatic logic [DATA_W-1:0] rnd_word();
        logic [DATA_W-1:0] w;
        for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Memory: registered address, unregistered read data, full-word writes.
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= rnd_word();
        end else if (bus.mem_chipselect && bus.mem_write) begin
            mem[bus.mem_address] <= bus.mem_writedata;
        end
        if (bus.mem_chipselect) rd_addr <= bus.mem_address;
    end
    assign bus.mem_readdata = mem[rd_addr];

    // Engine: result = input XOR mask, with configurable accept and result stalls.
    logic              pend;
    logic [DATA_W-1:0] pend_data;
    int                in_cnt, out_cnt;
    assign bus.eng_in_ready  = (in_cnt >= in_stall);
    assign bus.eng_out_valid = pend && (out_cnt >= out_stall);
    assign bus.eng_out_data  = pend_data;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend      <= 1'b0;
            pend_data <= '0;
            in_cnt    <= 0;
            out_cnt   <= 0;
        end else begin
            if (bus.eng_in_valid && bus.eng_in_ready) begin
                pend      <= 1'b1;
                pend_data <= bus.eng_in_data ^ mask;
                in_cnt    <= 0;
                out_cnt   <= 0;
            end else if (bus.eng_in_valid) begin
                in_cnt <= in_cnt + 1;
            end
            if (bus.eng_out_valid && bus.eng_out_ready) begin
                pend    <= 1'b0;
                out_cnt <= 0;
            end else if (pend) begin
                out_cnt <= out_cnt + 1;
            end
        end
    end

    // Bus monitor: write log, chipselect/done counts, byteenable and input-stability violations.
    int                wr_cnt = 0, cs_cnt = 0, done_cnt = 0, be_bad = 0, unstable = 0, in_hs = 0;
    logic              holding = 1'b0;
    logic [DATA_W-1:0] hold_data;
    logic [ADDR_W-1:0] wr_addrs [$];

    always @(posedge clk) begin
        if (bus.mem_chipselect) cs_cnt <= cs_cnt + 1;
        if (bus.mem_chipselect && bus.mem_write) begin
            wr_cnt <= wr_cnt + 1;
            wr_addrs.push_back(bus.mem_address);
            if (bus.mem_byteenable !== '1) be_bad <= be_bad + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (bus.eng_in_valid) begin
            if (holding && bus.eng_in_data !== hold_data) unstable <= unstable + 1;
            holding   <= !bus.eng_in_ready;
            hold_data <= bus.eng_in_data;
            if (bus.eng_in_ready) in_hs <= in_hs + 1;
        end else begin
            holding <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int wrap_base(input int b);
        return (b >= int'(DEPTH)) ? 0 : b;
    endfunction

    // Reference image: the current memory with n words from the (clamped) base XORed by mask.
    task automatic model(input int b, input int n);
        exp_mem = mem;
        for (int k = 0; k < n; k++) begin
            int a;
            a = (wrap_base(b) + k) % int'(DEPTH);
            exp_mem[a] = exp_mem[a] ^ mask;
        end
    endtask

    function automatic int img_diff();
        int d = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== exp_mem[i]) d++;
        return d;
    endfunction

    function automatic int addr_bad(input int w0, input int b, input int n);
        int bad = 0;
        if (wr_addrs.size() != w0 + n) bad++;
        for (int k = 0; k < n && w0 + k < wr_addrs.size(); k++)
            if (int'(wr_addrs[w0 + k]) != (wrap_base(b) + k) % int'(DEPTH)) bad++;
        return bad;
    endfunction

    function automatic logic [12:0] outvec();
        return {busy, done, aborted, |words_done, bus.mem_chipselect, bus.mem_write,
                |bus.mem_byteenable, bus.eng_in_valid, bus.eng_out_ready, |bus.mem_address,
                |bus.mem_writedata, |bus.eng_in_data, bus.mem_clken};
    endfunction

    task automatic start_job(input int b, input int n);
        start     = 1'b1;
        base_addr = ADDR_W'(b);
        num_words = ADDR_W'(n);
        tick();
        start = 1'b0;
    endtask

    // Cycle count includes the edge that sampled start; spur>0 pulses a stray start mid-job.
    task automatic wait_done(input string tag, input int spur, output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 3000) begin
            start = (cyc == spur);
            if (start) begin
                base_addr = ADDR_W'(100);
                num_words = ADDR_W'(7);
            end
            tick();
            start = 1'b0;
            cyc++;
        end
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
    endtask

    initial begin
        int cyc, w0, wc0, cs0, dc0, hs0, b, guard;
        logic [DATA_W-1:0] w9, w13;

        tick();
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        chk("reset_outs", 64'(outvec()), 64'h1);
        reset = 1'b0;
        tick();
        chk("post_reset_outs", 64'(outvec()), 64'h1);

        // Basic 3-word inversion.
        mask = '1;
        model(10, 3);
        w9 = mem[9]; w13 = mem[13];
        w0 = wr_addrs.size(); dc0 = done_cnt;
        start_job(10, 3);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_done("t1", 0, cyc);
        chk("t1_cycles", 64'(cyc), 64'd16);
        chk("t1_words_done", 64'(words_done), 64'd3);
        chk("t1_aborted", 64'(aborted), 64'd0);
        chk("t1_addrs", 64'(addr_bad(w0, 10, 3)), 64'd0);
        chk("t1_image", 64'(img_diff()), 64'd0);
        chk("t1_word9", 64'(mem[9] !== w9), 64'd0);
        chk("t1_word13", 64'(mem[13] !== w13), 64'd0);
        tick();
        chk("t1_done_pulse", 64'({done, busy}), 64'd0);
        chk("t1_done_count", 64'(done_cnt - dc0), 64'd1);

        // Address wrap at the end of memory.
        mask = rnd_word();
        model(3599, 4);
        w0 = wr_addrs.size();
        start_job(3599, 4);
        wait_done("t2", 0, cyc);
        chk("t2_cycles", 64'(cyc), 64'd21);
        chk("t2_words_done", 64'(words_done), 64'd4);
        chk("t2_addrs", 64'(addr_bad(w0, 3599, 4)), 64'd0);
        tick();
        chk("t2_image", 64'(img_diff()), 64'd0);

        // Abort during SEND of the second word of eight.
        mask = rnd_word();
        b = int'($urandom_range(0, DEPTH - 1));
        model(b, 2);
        w0 = wr_addrs.size(); hs0 = in_hs;
        start_job(b, 8);
        guard = 0;
        while (!(bus.eng_in_valid && in_hs == hs0 + 1) && guard < 200) begin
            tick();
            guard++;
        end
        chk("t5_reach_send2", 64'(guard < 200), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("t5", 0, cyc);
        chk("t5_words_done", 64'(words_done), 64'd2);
        chk("t5_aborted", 64'(aborted), 64'd1);
        chk("t5_addrs", 64'(addr_bad(w0, b, 2)), 64'd0);
        tick();
        chk("t5_image", 64'(img_diff()), 64'd0);

        // Zero-length job: no memory access, done right away, aborted cleared.
        cs0 = cs_cnt;
        start_job(5, 0);
        chk("t3_cycles_done", 64'(done), 64'd1);
        chk("t3_words_done", 64'(words_done), 64'd0);
        chk("t3_aborted", 64'(aborted), 64'd0);
        tick();
        tick();
        chk("t3_no_cs", 64'(cs_cnt - cs0), 64'd0);

        // Abort while idle is ignored; the following stalled job runs to completion.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        in_stall = 7; out_stall = 4;
        mask = rnd_word();
        b = int'($urandom_range(0, DEPTH - 1));
        model(b, 3);
        w0 = wr_addrs.size(); wc0 = wr_cnt;
        start_job(b, 3);
        wait_done("t4", 0, cyc);
        chk("t4_cycles", 64'(cyc), 64'd49);
        chk("t4_aborted", 64'(aborted), 64'd0);
        chk("t4_words_done", 64'(words_done), 64'd3);
        chk("t4_stable", 64'(unstable), 64'd0);
        tick();
        chk("t4_writes", 64'(wr_cnt - wc0), 64'd3);
        chk("t4_addrs", 64'(addr_bad(w0, b, 3)), 64'd0);
        chk("t4_byteenable", 64'(be_bad), 64'd0);
        chk("t4_image", 64'(img_diff()), 64'd0);

        // Reset in RECV of the first word abandons the job with no write and no done.
        in_stall = 0; out_stall = 3;
        mask = rnd_word();
        b = int'($urandom_range(0, DEPTH - 1));
        model(b, 0);
        wc0 = wr_cnt; dc0 = done_cnt;
        start_job(b, 4);
        guard = 0;
        while (!bus.eng_out_ready && guard < 50) begin
            tick();
            guard++;
        end
        chk("t6_reach_recv", 64'(guard < 50), 64'd1);
        reset = 1'b1;
        #1;
        chk("t6_reset_outs", 64'(outvec()), 64'h1);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("t6_no_write", 64'(wr_cnt - wc0), 64'd0);
        chk("t6_no_done", 64'(done_cnt - dc0), 64'd0);
        chk("t6_image", 64'(img_diff()), 64'd0);

        // Fresh job after reset, with a stray start pulsed mid-job.
        out_stall = 0;
        mask = rnd_word();
        b = int'($urandom_range(0, DEPTH - 1));
        model(b, 3);
        w0 = wr_addrs.size();
        start_job(b, 3);
        wait_done("t7", 4, cyc);
        chk("t7_cycles", 64'(cyc), 64'd16);
        chk("t7_words_done", 64'(words_done), 64'd3);
        chk("t7_addrs", 64'(addr_bad(w0, b, 3)), 64'd0);
        tick();
        tick();
        chk("t7_idle", 64'(busy), 64'd0);
        chk("t7_image", 64'(img_diff()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vid_mem_aes_sequencer.md
Name: vid_mem_aes_sequencer

Overview:
- Walks a contiguous, wrap-around range of 1024-bit words in the dual-port video on-chip memory through one memory port.
- Per word: read, hand the word to the AES engine over valid/ready, collect the engine result, write it back in place with all bytes enabled.
- Sits between the HPS-side control registers and the second memory port; the first port stays with the video/HPS path.

Parameters:
- DATA_W, 1024, memory word and AES engine payload width
- ADDR_W, 12, memory word-address width
- DEPTH, 3601, number of memory words; the address wraps at DEPTH
- BE_W, DATA_W/8 (128), byteenable width

Ports:
- clk  in  1  single clock for the block, memory port and engine
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a job when idle
- base_addr  in  ADDR_W  first word address, sampled on start
- num_words  in  ADDR_W  word count, sampled on start
- abort  in  1  pulse; ends the job at the next word boundary
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- aborted  out  1  set with done when the job ended by abort; cleared on the next start
- words_done  out  ADDR_W  words written back in the current or last job
- mem_address  out  ADDR_W  memory port address
- mem_chipselect  out  1  memory port select
- mem_write  out  1  memory write strobe
- mem_byteenable  out  BE_W  all ones during a write, else zero
- mem_writedata  out  DATA_W  engine result being written
- mem_clken  out  1  tied to 1
- mem_readdata  in  DATA_W  unregistered memory output; valid the cycle after the address is presented
- eng_in_valid  out  1  input word to the engine is valid
- eng_in_ready  in  1  engine accepts the input word
- eng_in_data  out  DATA_W  captured memory word
- eng_out_valid  in  1  engine result is valid
- eng_out_ready  out  1  block accepts the result
- eng_out_data  in  DATA_W  engine result

Behaviour:
- Reset values: all outputs 0 except mem_clken = 1. FSM goes to IDLE, counters clear. Reset mid-job abandons it without a write or a done pulse.
- FSM states and transitions:
  - IDLE: on start with num_words = 0, go to DONE (no memory access). On start otherwise, latch base_addr into addr and num_words into remaining, clear words_done and aborted, go to RD.
  - RD: one cycle; mem_chipselect = 1, mem_write = 0, mem_address = addr; go to CAP.
  - CAP: one cycle; register mem_readdata into the data buffer; go to SEND.
  - SEND: eng_in_valid = 1, eng_in_data = buffer. eng_in_data stays stable until eng_in_valid & eng_in_ready; then go to RECV.
  - RECV: eng_out_ready = 1. On eng_out_valid, register eng_out_data into the buffer; go to WR.
  - WR: one cycle; mem_chipselect = 1, mem_write = 1, mem_byteenable all ones, mem_writedata = buffer, mem_address = addr. Increment words_done and decrement remaining. Advance addr as addr = (addr = DEPTH-1) ? 0 : addr+1. Next state: DONE if remaining was 1 or abort is pending, else RD.
  - DONE: one cycle; done = 1, busy = 0 next cycle; go to IDLE.
- Abort handling: an abort pulse in any busy state sets abort_pending, which is consumed in WR. The in-flight word always completes. aborted is set together with done. abort in IDLE is ignored.
- start while busy or in DONE is ignored.
- base_addr >= DEPTH: clamp it to 0 at start.
- num_words > DEPTH: allowed; addresses wrap and words are revisited.
- Arithmetic: addr and remaining are ADDR_W unsigned; no overflow beyond the wrap rule.
- Minimum per-word latency is 5 cycles (RD, CAP, SEND, RECV, WR) with the engine ready and result valid immediately.
- The memory port never sees a read and a write in the same cycle. mem_chipselect is low in all other states.

Decomposition:
- Shared package vid_aes_pkg:
  - FSM state enum: IDLE, RD, CAP, SEND, RECV, WR, DONE
  - constants DATA_W = 1024, ADDR_W = 12, DEPTH = 3601, BE_W = 128
  - function next_addr(addr) implementing the DEPTH wrap
- No sub-module: the FSM, address counter and single data buffer stay in one module.

Test Plan:
- start, base_addr = 10, num_words = 3, engine always ready, result = input XOR all-ones:
  - words 10, 11, 12 are inverted in memory; words 9 and 13 are untouched
  - done after 3×5 + 1 cycles, words_done = 3, aborted = 0
- base_addr = 3599, num_words = 4 -> address sequence 3599, 3600, 0, 1; all four written back; done with words_done = 4.
- num_words = 0 -> no mem_chipselect ever; done pulses the cycle after start; words_done = 0.
- Engine stalls eng_in_ready low for 7 cycles and eng_out_valid low for 4 cycles per word -> eng_in_data stays stable while stalled; one write per word; result correct.
- abort pulsed during SEND of word 2 of 8 -> word 2 is written; done with aborted = 1 and words_done = 2; words 3..7 are untouched.
- reset asserted in RECV of word 1 -> all outputs 0 immediately, no write for word 1, no done. A new start afterwards runs normally. A second start pulsed mid-job is ignored (words_done unaffected).
